ds_pixel_writer: RTL and testbench

- Consumer end of the diamond-square generator's read-out handshake (gen_done / bus_ack / x, y, z).
- After the generator asserts done, pulls every height sample, maps it to an 8bpp RGB332 colour, and blits it as a CELL_PX x CELL_PX block into the VGA pixel buffer over an Avalon-MM write master.
- Sits between the generator and the pixel-buffer interconnect in the top level.

---
 rtl/ds_pkg.sv | 34 +++
 rtl/ds_height_cmap.sv | 30 +++
 rtl/ds_pixel_writer.sv | 162 ++++++++++++++++
 tb/tb_ds_pixel_writer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ds_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ds_pkg
// Summary  : Shared FSM encodings, RGB332 palette and screen defaults for the
//            diamond-square pixel writer.
// Revision : 1.0 - initial release
// ============================================================================
package ds_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACK     = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_WRITE   = 3'd4,
        S_NEXT    = 3'd5,
        S_DONE    = 3'd6
    } ds_state_t;

    localparam logic [7:0] c_rgb_water = 8'h03;
    localparam logic [7:0] c_rgb_grass = 8'h1C;
    localparam logic [7:0] c_rgb_rock  = 8'h8C;
    localparam logic [7:0] c_rgb_snow  = 8'hFF;

    localparam int unsigned c_screen_w_def = 640;
    localparam int unsigned c_screen_h_def = 480;

    // Replicate the top height bits into R, G and B so grey stays monotonic in z.
    function automatic logic [7:0] gray332(input logic [7:0] z);
        return {z[7:5], z[7:5], z[7:6]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ds_height_cmap.sv
`default_nettype none
// ============================================================================
// Module   : ds_height_cmap
// Summary  : Combinational height -> RGB332 colour map. DS_TERRAIN_COLORMAP_EN
//            selects a banded terrain palette; otherwise a grey ramp is used.
// Revision : 1.0 - initial release
// ============================================================================
module ds_height_cmap
    import ds_pkg::*;
(
    input  logic [7:0] i_z,
    output logic [7:0] o_rgb
);

    always_comb begin
        o_rgb = 8'h00;
`ifdef DS_TERRAIN_COLORMAP_EN
        unique case (i_z[7:6])
            2'd0:    o_rgb = c_rgb_water;
            2'd1:    o_rgb = c_rgb_grass;
            2'd2:    o_rgb = c_rgb_rock;
            default: o_rgb = c_rgb_snow;
        endcase
`else
        o_rgb = gray332(i_z);
`endif
    end

endmodule
`default_nettype wire

// File: rtl/ds_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module   : ds_pixel_writer
// Summary  : Pulls height samples from the diamond-square generator and blits
//            each as a CELL_PX x CELL_PX RGB332 block over Avalon-MM.
//            Palette selected by DS_TERRAIN_COLORMAP_EN (see ds_height_cmap).
// Revision : 1.0 - initial release
// ============================================================================
module ds_pixel_writer
    import ds_pkg::*;
#(
    parameter int unsigned DIM         = 9,
    parameter int unsigned CELL_PX     = 4,
    parameter int unsigned ORIGIN_X    = 0,
    parameter int unsigned ORIGIN_Y    = 0,
    parameter int unsigned SCREEN_W    = c_screen_w_def,
    parameter int unsigned SCREEN_H    = c_screen_h_def,
    parameter logic [31:0] PIXBUF_BASE = 32'h0000_0000,
    parameter int unsigned ACK_LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        gen_done,
    input  logic [9:0]  gen_x,
    input  logic [9:0]  gen_y,
    input  logic [7:0]  gen_z,
    output logic        bus_ack,
    output logic [31:0] avm_address,
    output logic        avm_write,
    output logic [7:0]  avm_writedata,
    input  logic        avm_waitrequest,
    output logic        frame_done,
    output logic [15:0] pixel_count
);

    localparam int unsigned        c_lat_w       = (ACK_LATENCY > 1) ? $clog2(ACK_LATENCY) : 1;
    localparam logic [c_lat_w-1:0] c_lat_last    = c_lat_w'(ACK_LATENCY - 1);
    localparam logic [3:0]         c_sub_last    = 4'(CELL_PX - 1);
    localparam logic [15:0]        c_frame_cells = 16'(DIM * DIM);

    ds_state_t          r_state;
    ds_state_t          w_state_nxt;
    logic [c_lat_w-1:0] r_lat_cnt;
    logic [9:0]         r_x;
    logic [9:0]         r_y;
    logic [7:0]         r_colour;
    logic [3:0]         r_sx;
    logic [3:0]         r_sy;
    logic [15:0]        r_pixel_count;
    logic               r_abort;

    logic [7:0]         w_cmap;
    logic [31:0]        w_px;
    logic [31:0]        w_py;
    logic [31:0]        w_addr;
    logic               w_in_range;
    logic               w_sub_last;
    logic               w_beat_done;
    logic [15:0]        w_count_inc;

    ds_height_cmap u_cmap (
        .i_z   (gen_z),
        .o_rgb (w_cmap)
    );

    // Screen position of the current sub-pixel; off-screen sub-pixels are skipped.
    always_comb begin
        w_px        = ORIGIN_X + 32'(r_x) * CELL_PX + 32'(r_sx);
        w_py        = ORIGIN_Y + 32'(r_y) * CELL_PX + 32'(r_sy);
        w_in_range  = (w_px < SCREEN_W) && (w_py < SCREEN_H);
        w_addr      = PIXBUF_BASE + w_py * SCREEN_W + w_px;
        w_sub_last  = (r_sx == c_sub_last) && (r_sy == c_sub_last);
        w_beat_done = !w_in_range || !avm_waitrequest;
        w_count_inc = r_pixel_count + 16'd1;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:    if (gen_done) w_state_nxt = S_ACK;
            S_ACK:     w_state_nxt = gen_done ? S_WAIT : S_IDLE;
            S_WAIT: begin
                if (!gen_done)                     w_state_nxt = S_IDLE;
                else if (r_lat_cnt == c_lat_last)  w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: w_state_nxt = S_WRITE;
            S_WRITE:   if (w_beat_done && w_sub_last) w_state_nxt = S_NEXT;
            S_NEXT: begin
                if (r_abort)                           w_state_nxt = S_IDLE;
                else if (w_count_inc == c_frame_cells) w_state_nxt = S_DONE;
                else                                   w_state_nxt = S_ACK;
            end
            S_DONE:    w_state_nxt = S_DONE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_lat_cnt     <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_colour      <= '0;
            r_sx          <= '0;
            r_sy          <= '0;
            r_pixel_count <= '0;
            r_abort       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            unique case (r_state)
                S_ACK: begin
                    r_lat_cnt <= '0;
                    if (!gen_done) r_pixel_count <= '0;
                end
                S_WAIT: begin
                    r_lat_cnt <= r_lat_cnt + 1'b1;
                    if (!gen_done) r_pixel_count <= '0;
                end
                S_CAPTURE: begin
                    r_x      <= gen_x;
                    r_y      <= gen_y;
                    r_colour <= w_cmap;
                    r_sx     <= '0;
                    r_sy     <= '0;
                    r_abort  <= !gen_done;
                end
                S_WRITE: begin
                    // A dropped gen_done still lets the current block finish.
                    if (!gen_done) r_abort <= 1'b1;
                    if (w_beat_done) begin
                        if (w_sub_last) begin
                            r_sx <= '0;
                            r_sy <= '0;
                        end else if (r_sx == c_sub_last) begin
                            r_sx <= '0;
                            r_sy <= r_sy + 4'd1;
                        end else begin
                            r_sx <= r_sx + 4'd1;
                        end
                    end
                end
                S_NEXT: begin
                    r_abort       <= 1'b0;
                    r_pixel_count <= r_abort ? 16'd0 : w_count_inc;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus_ack       = (r_state == S_ACK);
        avm_write     = (r_state == S_WRITE) && w_in_range;
        avm_address   = avm_write ? w_addr : 32'd0;
        avm_writedata = avm_write ? r_colour : 8'd0;
        frame_done    = (r_state == S_DONE);
        pixel_count   = r_pixel_count;
    end

endmodule
`default_nettype wire

// File: tb/tb_ds_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ds_pixel_writer
// Summary  : Directed self-checking bench for ds_pixel_writer (DIM=3, CELL_PX=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ds_pixel_writer;

`ifdef DS_TERRAIN_COLORMAP_EN
    localparam logic [7:0] EXP_Z200 = 8'hFF;
`else
    localparam logic [7:0] EXP_Z200 = 8'hDB;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        gen_done = 1'b0;
    logic [9:0]  gen_x = 10'd0;
    logic [9:0]  gen_y = 10'd0;
    logic [7:0]  gen_z = 8'd0;
    logic        avm_waitrequest = 1'b0;
    logic        bus_ack;
    logic [31:0] avm_address;
    logic        avm_write;
    logic [7:0]  avm_writedata;
    logic        frame_done;
    logic [15:0] pixel_count;

    always #5 clk = ~clk;

    ds_pixel_writer #(
        .DIM(3), .CELL_PX(4), .ORIGIN_X(0), .ORIGIN_Y(0),
        .SCREEN_W(640), .SCREEN_H(480), .PIXBUF_BASE(32'h0), .ACK_LATENCY(3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .gen_done        (gen_done),
        .gen_x           (gen_x),
        .gen_y           (gen_y),
        .gen_z           (gen_z),
        .bus_ack         (bus_ack),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .frame_done      (frame_done),
        .pixel_count     (pixel_count)
    );

    function automatic logic [7:0] cref(input logic [7:0] z);
`ifdef DS_TERRAIN_COLORMAP_EN
        if (z < 8'd64)       return 8'h03;
        else if (z < 8'd128) return 8'h1C;
        else if (z < 8'd192) return 8'h8C;
        else                 return 8'hFF;
`else
        return {z[7:5], z[7:5], z[7:6]};
`endif
    endfunction

    // Generator model: garbage right after an ack, the table entry from the 3rd cycle on.
    logic [9:0] tbl_x [64];
    logic [9:0] tbl_y [64];
    logic [7:0] tbl_z [64];
    int         m_ack = 0;
    int         m_sel = 0;
    logic [1:0] m_d = 2'd0;

    always @(posedge clk) begin
        if (bus_ack === 1'b1) begin
            m_sel <= m_ack;
            m_ack <= m_ack + 1;
            m_d   <= 2'd1;
            gen_x <= 10'h3FF;
            gen_y <= 10'h3FF;
            gen_z <= 8'h55;
        end else if (m_d == 2'd1) begin
            m_d <= 2'd2;
        end else if (m_d == 2'd2) begin
            m_d   <= 2'd0;
            gen_x <= tbl_x[m_sel[5:0]];
            gen_y <= tbl_y[m_sel[5:0]];
            gen_z <= tbl_z[m_sel[5:0]];
        end
    end

    // Bus monitor: ack timestamps, completed beats, stall stability.
    int          cyc = 0;
    int          ack_overlap = 0;
    int          stab_err = 0;
    logic        prev_ack = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    logic [7:0]  prev_data = 8'd0;
    int          ack_t [$];
    logic [31:0] beat_addr [$];
    logic [7:0]  beat_data [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus_ack === 1'b1) begin
            ack_t.push_back(cyc);
            if (prev_ack) ack_overlap <= ack_overlap + 1;
        end
        prev_ack <= (bus_ack === 1'b1);
        if (avm_write === 1'b1 && avm_waitrequest === 1'b0) begin
            beat_addr.push_back(avm_address);
            beat_data.push_back(avm_writedata);
        end
        if (prev_stall && (avm_write !== 1'b1 || avm_address !== prev_addr || avm_writedata !== prev_data))
            stab_err <= stab_err + 1;
        prev_stall <= (avm_write === 1'b1) && avm_waitrequest && reset;
        prev_addr  <= avm_address;
        prev_data  <= avm_writedata;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int b0;
        for (int i = 0; i < 64; i++) begin
            tbl_x[i] = 10'd0;
            tbl_y[i] = 10'd0;
            tbl_z[i] = 8'd0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_bus_ack", bus_ack, 0);
        chk("rst_avm_write", avm_write, 0);
        chk("rst_avm_address", avm_address, 0);
        chk("rst_avm_writedata", avm_writedata, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_pixel_count", pixel_count, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_no_ack", bus_ack, 0);

        // Full 3x3 frame, no stalls
        n  = ack_t.size();
        b0 = beat_addr.size();
        for (int i = 0; i < 9; i++) begin
            tbl_x[n+i] = 10'(i % 3);
            tbl_y[n+i] = 10'(i / 3);
            tbl_z[n+i] = 8'(30 * i);
        end
        gen_done = 1'b1;
        for (int k = 0; k < 1000 && frame_done !== 1'b1; k++) @(negedge clk);
        chk("a_frame_done", frame_done, 1);
        chk("a_pixel_count", pixel_count, 9);
        chk("a_ack_count", ack_t.size() - n, 9);
        chk("a_beat_count", beat_addr.size() - b0, 144);
        chk("a_ack_overlap", ack_overlap, 0);
        if (ack_t.size() >= n + 9)
            for (int i = 0; i < 8; i++) chk("a_cell_cycles", ack_t[n+i+1] - ack_t[n+i], 22);
        if (beat_addr.size() >= b0 + 144)
            for (int c = 0; c < 9; c++)
                for (int sy = 0; sy < 4; sy++)
                    for (int sx = 0; sx < 4; sx++) begin
                        chk("a_addr", beat_addr[b0 + c*16 + sy*4 + sx],
                            32'(((c / 3) * 4 + sy) * 640 + (c % 3) * 4 + sx));
                        chk("a_data", 32'(beat_data[b0 + c*16 + sy*4 + sx]), 32'(cref(8'(30 * c))));
                    end
        repeat (5) @(negedge clk);
        chk("a_hold_frame_done", frame_done, 1);
        chk("a_hold_bus_ack", bus_ack, 0);
        chk("a_hold_avm_write", avm_write, 0);
        chk("a_hold_pixel_count", pixel_count, 9);

        // Cell (2,1), z=200, 5-cycle stall on the second beat
        gen_done = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk("b_rst_pixel_count", pixel_count, 0);
        chk("b_rst_frame_done", frame_done, 0);
        n  = ack_t.size();
        b0 = beat_addr.size();
        tbl_x[n] = 10'd2;  tbl_y[n] = 10'd1;  tbl_z[n] = 8'd200;
        tbl_x[n+1] = 10'd0; tbl_y[n+1] = 10'd0; tbl_z[n+1] = 8'd0;
        gen_done = 1'b1;
        for (int k = 0; k < 50 && avm_write !== 1'b1; k++) @(negedge clk);
        chk("b_first_addr", avm_address, 2568);
        @(negedge clk);
        avm_waitrequest = 1'b1;
        chk("b_second_addr", avm_address, 2569);
        repeat (5) begin
            @(negedge clk);
            chk("b_stall_write", avm_write, 1);
            chk("b_stall_addr", avm_address, 2569);
            chk("b_stall_data", avm_writedata, EXP_Z200);
        end
        avm_waitrequest = 1'b0;
        for (int k = 0; k < 60 && pixel_count !== 16'd1; k++) @(negedge clk);
        chk("b_pixel_count", pixel_count, 1);
        chk("b_beat_count", beat_addr.size() - b0, 16);
        if (beat_addr.size() >= b0 + 16)
            for (int i = 0; i < 16; i++) begin
                chk("b_addr", beat_addr[b0+i], 32'((4 + i / 4) * 640 + 8 + i % 4));
                chk("b_data", beat_data[b0+i], EXP_Z200);
            end

        // gen_done dropped in WAIT
        for (int k = 0; k < 10 && bus_ack !== 1'b1; k++) @(negedge clk);
        chk("c_ack", bus_ack, 1);
        @(negedge clk);
        gen_done = 1'b0;
        @(negedge clk);
        chk("c_abort_pixel_count", pixel_count, 0);
        chk("c_abort_bus_ack", bus_ack, 0);
        n  = ack_t.size();
        b0 = beat_addr.size();
        repeat (8) @(negedge clk);
        chk("c_no_beats", beat_addr.size() - b0, 0);
        chk("c_no_acks", ack_t.size() - n, 0);
        chk("c_idle_write", avm_write, 0);
        chk("c_idle_pixel_count", pixel_count, 0);

        // Restart with fully clipped cells, then reset during a stalled beat
        tbl_x[n] = 10'd160;  tbl_y[n] = 10'd0;    tbl_z[n] = 8'd50;
        tbl_x[n+1] = 10'd0;  tbl_y[n+1] = 10'd120; tbl_z[n+1] = 8'd50;
        tbl_x[n+2] = 10'd1;  tbl_y[n+2] = 10'd1;   tbl_z[n+2] = 8'd100;
        gen_done = 1'b1;
        for (int k = 0; k < 10 && bus_ack !== 1'b1; k++) @(negedge clk);
        chk("d_restart_ack", bus_ack, 1);
        for (int k = 0; k < 100 && pixel_count !== 16'd2; k++) @(negedge clk);
        chk("d_clip_pixel_count", pixel_count, 2);
        chk("d_clip_no_beats", beat_addr.size() - b0, 0);
        if (ack_t.size() >= n + 2) chk("d_clip_cell_cycles", ack_t[n+1] - ack_t[n], 22);
        avm_waitrequest = 1'b1;
        for (int k = 0; k < 20 && avm_write !== 1'b1; k++) @(negedge clk);
        chk("d_stall_addr", avm_address, 2564);
        chk("d_stall_data", avm_writedata, cref(8'd100));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("d_rst_avm_write", avm_write, 0);
        chk("d_rst_bus_ack", bus_ack, 0);
        chk("d_rst_frame_done", frame_done, 0);
        chk("d_rst_pixel_count", pixel_count, 0);
        chk("d_rst_avm_address", avm_address, 0);
        reset = 1'b1;
        avm_waitrequest = 1'b0;
        gen_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("d_stall_stability", stab_err, 0);

        // gen_done dropped during WRITE: block completes, then idle
        n  = ack_t.size();
        b0 = beat_addr.size();
        tbl_x[n] = 10'd0;   tbl_y[n] = 10'd2;   tbl_z[n] = 8'd255;
        tbl_x[n+1] = 10'd1; tbl_y[n+1] = 10'd2; tbl_z[n+1] = 8'd30;
        gen_done = 1'b1;
        for (int k = 0; k < 20 && avm_write !== 1'b1; k++) @(negedge clk);
        chk("e_first_addr", avm_address, 5120);
        gen_done = 1'b0;
        repeat (40) @(negedge clk);
        chk("e_beat_count", beat_addr.size() - b0, 16);
        chk("e_ack_count", ack_t.size() - n, 1);
        chk("e_pixel_count", pixel_count, 0);
        chk("e_idle_write", avm_write, 0);
        if (beat_addr.size() >= b0 + 16) begin
            chk("e_last_addr", beat_addr[b0+15], 7043);
            chk("e_last_data", beat_data[b0+15], cref(8'd255));
        end
        chk("e_ack_overlap", ack_overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
